detect_sink: RTL

- Receiving end of the classifier's detection-position stream.
- Accepts packed 32-bit detect words with valid/ready/eot handshake and unpacks them into scale/y/x.
- Buffers them in a FIFO for a host-side reader, counts detections per frame, and raises a sticky completion interrupt once the end-of-frame marker has been read out.
- Sits between the detector top level and the host bus bridge.

---
 rtl/det_pkg.sv | 38 +++
 rtl/detect_sink_sync_fifo.sv | 77 +++++++
 rtl/detect_sink.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/det_pkg.sv
// Package: det_pkg
// Shared types and helpers for the detection sink.
//   calc_w_x / calc_w_y  : coordinate field widths from the image size
//   calc_filler_w        : unused high bits of a packed 32-bit detect word
//   det_entry_t          : FIFO entry layout for the default 320x240 image
//   det_state_t          : collection state machine states
package det_pkg;

   function automatic int unsigned calc_w_x(input int unsigned img_width);
      return $clog2(img_width);
   endfunction

   function automatic int unsigned calc_w_y(input int unsigned img_height);
      return $clog2(img_height);
   endfunction

   function automatic int unsigned calc_filler_w(input int unsigned img_width,
                                                 input int unsigned img_height);
      return 32 - 8 - calc_w_y(img_height) - calc_w_x(img_width);
   endfunction

   localparam int unsigned DEF_W_X = calc_w_x(320);
   localparam int unsigned DEF_W_Y = calc_w_y(240);

   typedef struct packed {
      logic               eot;
      logic [7:0]         scale;
      logic [DEF_W_Y-1:0] y;
      logic [DEF_W_X-1:0] x;
   } det_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DRAIN
   } det_state_t;

endpackage

// File: rtl/detect_sink_sync_fifo.sv
// Module: sync_fifo
// Single-clock FIFO with the head entry presented directly from storage.
//   clk, rst  : clock, synchronous active-high reset
//   flush     : synchronous empty (wins over push/pop)
//   push, din : write request and data (ignored when full)
//   pop       : consume head (ignored when empty)
//   dout      : head entry, zero when empty
//   full, empty, count : occupancy status
module sync_fifo #(
   parameter  int unsigned WIDTH = 8,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = AW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == DEPTH_C);
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/detect_sink.sv
// Module: detect_sink
// Receives packed detect words (valid/ready/eot), unpacks scale/y/x, buffers
// them for a host reader, counts detections per frame and raises a sticky
// done_irq once the end-of-frame marker has been read out.
//   clk, rst (sync, active-high), frame_start : clock, reset, frame arm/abort
//   det_valid/det_ready/det_eot/det_data      : detect word input
//   out_valid/out_ready/out_eot/out_scale/out_y/out_x : FIFO head to host
//   det_count, err, done_irq                  : per-frame status
// Optional: DETECT_SINK_DROP_ON_FULL_EN -- never back-pressure; words that
// find the FIFO full are dropped and counted on drop_count.
module detect_sink
   import det_pkg::*;
#(
   parameter  int unsigned IMG_WIDTH  = 320,
   parameter  int unsigned IMG_HEIGHT = 240,
   parameter  int unsigned FIFO_DEPTH = 64,
   parameter  int unsigned W_CNT      = 16,
   localparam int unsigned W_X        = calc_w_x(IMG_WIDTH),
   localparam int unsigned W_Y        = calc_w_y(IMG_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_start,
   input  logic             det_valid,
   output logic             det_ready,
   input  logic             det_eot,
   input  logic [31:0]      det_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_eot,
   output logic [7:0]       out_scale,
   output logic [W_Y-1:0]   out_y,
   output logic [W_X-1:0]   out_x,
   output logic [W_CNT-1:0] det_count,
   output logic             err,
   output logic             done_irq
`ifdef DETECT_SINK_DROP_ON_FULL_EN
   ,
   output logic [15:0]      drop_count
`endif
);

   localparam int unsigned FILLER_W = calc_filler_w(IMG_WIDTH, IMG_HEIGHT);
   localparam int unsigned ENTRY_W  = 1 + 8 + W_Y + W_X;
   localparam int unsigned CW       = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic           eot;
      logic [7:0]     scale;
      logic [W_Y-1:0] y;
      logic [W_X-1:0] x;
   } entry_t;

   det_state_t      state_q, state_d;
   logic [W_CNT-1:0] det_count_q, det_count_d;
   logic            err_q, err_d;
   logic            done_irq_q, done_irq_d;

   entry_t          push_entry, head;
   logic            fifo_push, fifo_flush, fifo_pop;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;
   logic [ENTRY_W-1:0] fifo_dout;

   logic [7:0]      in_scale;
   logic [W_Y-1:0]  in_y;
   logic [W_X-1:0]  in_x;
   logic            in_range, det_accept;

   logic            unused_bits;

   assign in_x     = det_data[0 +: W_X];
   assign in_y     = det_data[W_X +: W_Y];
   assign in_scale = det_data[W_X+W_Y +: 8];
   assign in_range = (32'(in_x) < IMG_WIDTH) && (32'(in_y) < IMG_HEIGHT);

   assign unused_bits = ^{det_data[31 -: FILLER_W], fifo_count, fifo_full};

   // frame_start gates ready so a word offered in an abort cycle is refused.
`ifdef DETECT_SINK_DROP_ON_FULL_EN
   localparam logic [CW-1:0] SLOT_LIMIT = CW'(FIFO_DEPTH - 1);
   logic [15:0] drop_count_q, drop_count_d;
   assign det_ready  = (state_q == COLLECT) & ~frame_start;
   assign drop_count = drop_count_q;
`else
   assign det_ready  = (state_q == COLLECT) & ~fifo_full & ~frame_start;
`endif

   assign det_accept = det_valid & det_ready;
   assign head       = entry_t'(fifo_dout);
   assign out_valid  = ~fifo_empty;
   assign fifo_pop   = out_ready & out_valid;
   assign out_eot    = head.eot;
   assign out_scale  = head.scale;
   assign out_y      = head.y;
   assign out_x      = head.x;
   assign det_count  = det_count_q;
   assign err        = err_q;
   assign done_irq   = done_irq_q;

   always_comb begin
      state_d     = state_q;
      det_count_d = det_count_q;
      err_d       = err_q;
      done_irq_d  = done_irq_q;
      fifo_push   = 1'b0;
      fifo_flush  = 1'b0;
      push_entry  = '0;
`ifdef DETECT_SINK_DROP_ON_FULL_EN
      drop_count_d = drop_count_q;
`endif
      if (frame_start) begin
         fifo_flush  = 1'b1;
         det_count_d = '0;
         err_d       = 1'b0;
         done_irq_d  = 1'b0;
         state_d     = COLLECT;
`ifdef DETECT_SINK_DROP_ON_FULL_EN
         drop_count_d = '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: ;
            COLLECT: begin
               if (det_accept) begin
                  if (det_eot) begin
                     fifo_push      = 1'b1;
                     push_entry.eot = 1'b1;
                     state_d        = DRAIN;
                  end else if (in_range) begin
                     push_entry.scale = in_scale;
                     push_entry.y     = in_y;
                     push_entry.x     = in_x;
`ifdef DETECT_SINK_DROP_ON_FULL_EN
                     // Last slot stays free for the end-of-frame marker.
                     if (fifo_count < SLOT_LIMIT) begin
                        fifo_push = 1'b1;
                        if (det_count_q != '1) det_count_d = det_count_q + W_CNT'(1);
                     end else if (drop_count_q != '1) begin
                        drop_count_d = drop_count_q + 16'd1;
                     end
`else
                     fifo_push = 1'b1;
                     if (det_count_q != '1) det_count_d = det_count_q + W_CNT'(1);
`endif
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (fifo_pop && head.eot) begin
                  done_irq_d = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         det_count_q <= '0;
         err_q       <= 1'b0;
         done_irq_q  <= 1'b0;
`ifdef DETECT_SINK_DROP_ON_FULL_EN
         drop_count_q <= '0;
`endif
      end else begin
         state_q     <= state_d;
         det_count_q <= det_count_d;
         err_q       <= err_d;
         done_irq_q  <= done_irq_d;
`ifdef DETECT_SINK_DROP_ON_FULL_EN
         drop_count_q <= drop_count_d;
`endif
      end
   end

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (fifo_flush),
      .push  (fifo_push),
      .din   (push_entry),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule
